// File: rtl/dmem_port.sv
// dmem_port: M-stage data memory port with store lane steering, load
// extension, alignment checking and a response timeout.
module dmem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  st_size,
    input  logic [2:0]  ld_size,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    lane_q;
    logic [1:0]    lsz_q;
    logic          lun_q;
    logic [1:0]    size;
    logic          misal;
    logic [3:0]    mask_n;
    logic [31:0]   data_n;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext;

    assign size    = req_we ? st_size : ld_size[1:0];
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        misal = 1'b0;
        unique case (1'b1)
            size == 2'b00: misal = 1'b0;
            size == 2'b01: misal = req_addr[0];
            default:       misal = |req_addr[1:0];
        endcase
    end

    always_comb begin
        mask_n = 4'b0000;
        data_n = req_wdata;
        if (req_we) begin
            unique case (1'b1)
                st_size == 2'b00: begin
                    mask_n = 4'b0001 << req_addr[1:0];
                    data_n = {4{req_wdata[7:0]}};
                end
                st_size == 2'b01: begin
                    mask_n = 4'b0011 << req_addr[1:0];
                    data_n = {2{req_wdata[15:0]}};
                end
                default: mask_n = 4'b1111;
            endcase
        end
    end

    // Extraction works straight off the response bus so DONE already
    // presents the extended value.
    assign byte_sel = mem_resp_data[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];

    always_comb begin
        ext = mem_resp_data;
        unique case (1'b1)
            lsz_q == 2'b00: ext = {{24{~lun_q & byte_sel[7]}}, byte_sel};
            lsz_q == 2'b01: ext = {{16{~lun_q & half_sel[15]}}, half_sel};
            default:        ext = mem_resp_data;
        endcase
    end

    assign stall = !reset &&
                   ((state == IDLE && req_valid && !misal) ||
                    state == REQ || state == WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lane_q        <= 2'b00;
            lsz_q         <= 2'b00;
            lun_q         <= 1'b0;
            ld_valid      <= 1'b0;
            ld_data       <= 32'd0;
            err           <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= 30'd0;
            mem_req_data  <= 32'd0;
            mem_req_mask  <= 4'b0000;
        end else begin
            ld_valid <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && misal) begin
                        err <= 1'b1;
                    end else if (req_valid) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= req_we;
                        mem_req_addr  <= req_addr[31:2];
                        mem_req_data  <= data_n;
                        mem_req_mask  <= mask_n;
                        lane_q        <= req_addr[1:0];
                        lsz_q         <= ld_size[1:0];
                        lun_q         <= ld_size[2];
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= mem_req_rw ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // A response in the final counted cycle beats the timeout.
                    if (mem_resp_valid) begin
                        state    <= DONE;
                        ld_valid <= 1'b1;
                        ld_data  <= ext;
                    end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        state    <= DONE;
                        ld_valid <= 1'b1;
                        ld_data  <= 32'd0;
                        err      <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles without a memory response before an error is raised.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 req_valid  in  1  the M-stage memory access is present this cycle.
REQ-005 req_we  in  1  1 = store, 0 = load; driven from DCache_WE.
REQ-006 req_addr  in  32  byte address, taken from the ALU result.
REQ-007 req_wdata  in  32  store data, unshifted and LSB-aligned.
REQ-008 st_size  in  2  store size from func3[1:0]: 00 = SB, 01 = SH, 10 = SW.
REQ-009 ld_size  in  3  load size from func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 stall  out  1  freezes the pipeline while an access is outstanding.
REQ-011 ld_valid  out  1  one-cycle pulse; ld_data holds the final writeback value.
REQ-012 ld_data  out  32  load result, already extended.
REQ-013 err  out  1  one-cycle pulse on a misaligned access or a timeout.
REQ-014 mem_req_valid / mem_req_ready  out / in  1 / 1  request handshake to the backing memory.
REQ-015 mem_req_rw  out  1  1 = write.
REQ-016 mem_req_addr  out  30  word address, equal to req_addr[31:2].
REQ-017 mem_req_data  out  32  store data replicated into the byte lanes.
REQ-018 mem_req_mask  out  4  byte-lane write enables.
REQ-019 mem_resp_valid / mem_resp_data  in / in  1 / 32  read response from the backing memory.

Function
REQ-020 The block SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-021 In IDLE, when req_valid=1 and the access is aligned, the block SHALL capture all req_* inputs, drive stall=1 combinationally in that same cycle, and go to REQ.
REQ-022 Alignment rules:
- SH, LH and LHU are misaligned when addr[0]=1.
- SW and LW are misaligned when addr[1:0]≠0.
- Bytes are always aligned.
REQ-023 For a misaligned access in IDLE, the block SHALL:
- issue no memory request;
- pulse err=1 in the next cycle;
- keep stall=0;
- stay in IDLE.
REQ-024 In REQ, mem_req_valid SHALL be 1, with the addr, rw, data and mask fields held constant until mem_req_ready=1.
- On handshake for a store: go to DONE.
- On handshake for a load: go to WAIT and clear the timeout counter.
REQ-025 Store lane generation:
- SB: mask = 0001 shifted left by addr[1:0]; data = byte replicated ×4.
- SH: mask = 0011 shifted left by addr[1:0]; data = halfword replicated ×2.
- SW: mask = 1111; data unchanged.
- Loads: mask = 0000.
REQ-026 In WAIT:
- mem_resp_valid=1 SHALL capture mem_resp_data and go to DONE.
- mem_resp_valid in any state other than WAIT SHALL be ignored.
REQ-027 In WAIT, the counter SHALL increment every cycle without a response.
- When it reaches TIMEOUT_CYCLES, the block SHALL go to DONE with load data forced to 0 and err pulsed in DONE.
- A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (no error).
REQ-028 Load extraction from the captured word, with the lane selected by addr[1:0]:
- LB: sign-extend the selected byte.
- LBU: zero-extend the selected byte.
- LH: sign-extend the halfword at addr[1].
- LHU: zero-extend the halfword at addr[1].
- LW: the whole word.
REQ-029 In DONE, the block SHALL drive stall=0 and pulse ld_valid=1 for loads only, hold ld_data valid, and return to IDLE.
REQ-030 stall SHALL be 1 in REQ and in WAIT.
- Latency from acceptance to stall release = 1 + request-wait cycles + response cycles.
REQ-031 A req_valid seen in DONE SHALL be ignored.
- The pipeline presents the next access no earlier than the cycle after stall falls.
REQ-032 ld_data SHALL hold its value until the next load completes.

Reset
REQ-033 When reset is asserted, the block SHALL:
- go to IDLE;
- clear the counter and all captured registers;
- drive stall, ld_valid, err, mem_req_valid, mem_req_rw and mem_req_mask to 0 and ld_data to 0.
REQ-034 A reset during REQ or WAIT SHALL abandon the access with no completion pulse.
- A late mem_resp_valid after reset is ignored.

Verification
REQ-035 Store: SB, addr=0x1003, wdata=0x000000A5, ready=1 immediately.
- Expect mem_req_mask=1000 and mem_req_data=0xA5A5A5A5.
- Expect stall for 2 cycles and no ld_valid.
REQ-036 Load: LH, addr=0x2002, response 0x8001_1234 after 3 WAIT cycles.
- Expect ld_data=0xFFFF8001 and a single ld_valid pulse.
- Expect stall released in DONE.
REQ-037 Load: LBU, addr=0x2001, response 0x0000_F000.
- Expect ld_data=0x000000F0.
REQ-038 Misaligned: LW, addr=0x3002.
- Expect no mem_req_valid, a one-cycle err pulse, and stall=0 throughout.
REQ-039 Timeout: TIMEOUT_CYCLES=4 and no response.
- Expect err and ld_valid together, ld_data=0, and a return to IDLE.
REQ-040 Reset in WAIT followed by a late mem_resp_valid.
- Expect stall=0 immediately, and no ld_valid and no state change afterwards.
